// File: rtl/if_fetch_pkg.sv
// Shared fetch-side definitions: widths, reset vector, NOP encoding and the
// fetch FSM state type, also consumed by IF/ID and decode.
package if_fetch_pkg;

  localparam int PC_WIDTH    = 12;
  localparam int INSTR_WIDTH = 32;

  localparam logic [PC_WIDTH-1:0]    RESET_PC  = 12'h000;
  localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  // Word-align a byte address by clearing the two low bits.
  function automatic logic [PC_WIDTH-1:0] align_pc(input logic [PC_WIDTH-1:0] addr);
    return {addr[PC_WIDTH-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_pc_reg.sv
// Program counter register: synchronous reset to the boot vector, with
// load / increment-by-4 / hold selected by the fetch control.
module pc_reg #(
  parameter int                     PC_WIDTH = if_fetch_pkg::PC_WIDTH,
  parameter logic [PC_WIDTH-1:0]    RESET_PC = if_fetch_pkg::RESET_PC
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [PC_WIDTH-1:0] load_val,
  input  logic                inc,
  output logic [PC_WIDTH-1:0] pc_q
);
  import if_fetch_pkg::*;

  localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(4);

  logic [PC_WIDTH-1:0] pc_d;

  // Load wins over increment so a redirect is never lost to a plain advance.
  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = load_val;
    end else if (inc) begin
      pc_d = pc_q + PC_STEP;
    end else begin
      pc_d = pc_q;
    end
  end

  // PC state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: sequences a 1-cycle-latency instruction memory and
// presents pc_4/instruction to IF/ID with stall, redirect and halt handling.
module if_fetch #(
  parameter int                     PC_WIDTH    = if_fetch_pkg::PC_WIDTH,
  parameter int                     INSTR_WIDTH = if_fetch_pkg::INSTR_WIDTH,
  parameter logic [PC_WIDTH-1:0]    RESET_PC    = if_fetch_pkg::RESET_PC
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   go,
  input  logic                   redirect,
  input  logic [PC_WIDTH-1:0]    redirect_target,
  input  logic                   halt_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_data,
  output logic [PC_WIDTH-1:0]    pc_4,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic                   if_valid,
  output logic                   halted,
  output logic [31:0]            fetch_count
);
  import if_fetch_pkg::*;

  localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(4);

  fetch_state_t        state_q, state_d;
  logic [PC_WIDTH-1:0] f_pc_q, f_pc_d;
  logic                f_valid_q, f_valid_d;
  logic [31:0]         fetch_count_q, fetch_count_d;

  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] target_s;
  logic                pc_load_s;
  logic                pc_inc_s;
  logic                unused_target_bits;

  assign target_s           = align_pc(redirect_target);
  assign unused_target_bits = ^redirect_target[1:0];

  pc_reg #(
    .PC_WIDTH (PC_WIDTH),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk      (clk),
    .rst      (rst),
    .load     (pc_load_s),
    .load_val (target_s + PC_STEP),
    .inc      (pc_inc_s),
    .pc_q     (pc_q)
  );

  // Redirect and halt kill the fetch in the same cycle so IF/ID takes a bubble.
  assign if_valid    = f_valid_q & (state_q == RUN) & ~redirect & ~halt_req;
  assign instruction = if_valid ? imem_data : INSTR_WIDTH'(NOP_INSTR);
  assign pc_4        = f_pc_q + PC_STEP;
  assign halted      = (state_q == HALT);
  assign fetch_count = fetch_count_q;

  // Memory address select; a stall re-reads f_pc so imem_data stays stable.
  always_comb begin
    imem_addr = pc_q;
    case (state_q)
      BOOT: imem_addr = pc_q;
      RUN: begin
        if (redirect) begin
          imem_addr = target_s;
        end else if (go) begin
          imem_addr = pc_q;
        end else begin
          imem_addr = f_pc_q;
        end
      end
      HALT:    imem_addr = f_pc_q;
      default: imem_addr = pc_q;
    endcase
  end

  // Next-state logic for the FSM, the fetch tracking registers and the PC.
  always_comb begin
    state_d       = state_q;
    f_pc_d        = f_pc_q;
    f_valid_d     = f_valid_q;
    pc_load_s     = 1'b0;
    pc_inc_s      = 1'b0;
    fetch_count_d = (if_valid & go) ? fetch_count_q + 32'd1 : fetch_count_q;
    case (state_q)
      BOOT: begin
        f_pc_d    = pc_q;
        f_valid_d = 1'b1;
        pc_inc_s  = 1'b1;
        state_d   = RUN;
      end
      RUN: begin
        if (halt_req) begin
          state_d   = HALT;
          f_valid_d = 1'b0;
        end else if (redirect) begin
          f_pc_d    = target_s;
          f_valid_d = 1'b1;
          pc_load_s = 1'b1;
        end else if (go) begin
          f_pc_d    = pc_q;
          f_valid_d = 1'b1;
          pc_inc_s  = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d   = BOOT;
        f_valid_d = 1'b0;
      end
    endcase
  end

  // Fetch state registers; reset discards any in-flight fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= BOOT;
      f_pc_q        <= {PC_WIDTH{1'b0}};
      f_valid_q     <= 1'b0;
      fetch_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      f_pc_q        <= f_pc_d;
      f_valid_q     <= f_valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Table-driven, scoreboarded bench for if_fetch against a 1-cycle-latency
// memory model that returns 32'h1000_0000 | address.
module tb_if_fetch;

  logic        clk;
  logic        rst;
  logic        go;
  logic        redirect;
  logic [11:0] redirect_target;
  logic        halt_req;
  logic [11:0] imem_addr;
  logic [31:0] imem_data;
  logic [11:0] pc_4;
  logic [31:0] instruction;
  logic        if_valid;
  logic        halted;
  logic [31:0] fetch_count;

  typedef struct {
    logic        rst;
    logic        go;
    logic        redir;
    logic [11:0] tgt;
    logic        halt;
    logic        chk_addr;
    logic [11:0] addr;
    logic        valid;
    logic [11:0] pc4;
    logic        hlt;
    logic [31:0] cnt;
  } vec_t;

  vec_t tbl [24];
  vec_t sb_q [$];
  int   n_checks;
  int   n_fail;

  if_fetch dut (
    .clk             (clk),
    .rst             (rst),
    .go              (go),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .halt_req        (halt_req),
    .imem_addr       (imem_addr),
    .imem_data       (imem_data),
    .pc_4            (pc_4),
    .instruction     (instruction),
    .if_valid        (if_valid),
    .halted          (halted),
    .fetch_count     (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) imem_data <= 32'h1000_0000 | {20'h0, imem_addr};

  function automatic vec_t mk(input logic r, input logic g, input logic rd,
                              input logic [11:0] t, input logic h, input logic ca,
                              input logic [11:0] a, input logic v, input logic [11:0] p,
                              input logic hl, input logic [31:0] c);
    vec_t x;
    x.rst = r; x.go = g; x.redir = rd; x.tgt = t; x.halt = h;
    x.chk_addr = ca; x.addr = a; x.valid = v; x.pc4 = p; x.hlt = hl; x.cnt = c;
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    vec_t        e;
    logic [11:0] fpc;
    logic [31:0] exp_instr;
    rst             = v.rst;
    go              = v.go;
    redirect        = v.redir;
    redirect_target = v.tgt;
    halt_req        = v.halt;
    sb_q.push_back(v);
    #3;
    n_checks++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s scoreboard: got empty queue expected entry", tag);
    end else begin
      e         = sb_q.pop_front();
      fpc       = e.pc4 - 12'd4;
      exp_instr = e.valid ? (32'h1000_0000 | {20'h0, fpc}) : 32'h0000_0000;
      if (e.chk_addr) check({tag, " imem_addr"}, {20'h0, imem_addr}, {20'h0, e.addr});
      check({tag, " if_valid"}, {31'h0, if_valid}, {31'h0, e.valid});
      check({tag, " pc_4"}, {20'h0, pc_4}, {20'h0, e.pc4});
      check({tag, " instruction"}, instruction, exp_instr);
      check({tag, " halted"}, {31'h0, halted}, {31'h0, e.hlt});
      check({tag, " fetch_count"}, fetch_count, e.cnt);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1; go = 1'b0; redirect = 1'b0; redirect_target = 12'h000; halt_req = 1'b0;

    //            rst   go    redir tgt      halt  chk   addr     vld   pc4      hlt   cnt
    tbl[0]  = mk(1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 1'b1, 12'h000, 1'b0, 12'h004, 1'b0, 32'd0);
    tbl[1]  = mk(1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 1'b1, 12'h004, 1'b1, 12'h004, 1'b0, 32'd0);
    tbl[2]  = mk(1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 1'b1, 12'h008, 1'b1, 12'h008, 1'b0, 32'd1);
    tbl[3]  = mk(1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 12'h008, 1'b1, 12'h00C, 1'b0, 32'd2);
    tbl[4]  = mk(1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 12'h008, 1'b1, 12'h00C, 1'b0, 32'd2);
    tbl[5]  = mk(1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 12'h008, 1'b1, 12'h00C, 1'b0, 32'd2);
    tbl[6]  = mk(1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 1'b1, 12'h00C, 1'b1, 12'h00C, 1'b0, 32'd2);
    tbl[7]  = mk(1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 1'b1, 12'h010, 1'b1, 12'h010, 1'b0, 32'd3);
    tbl[8]  = mk(1'b0, 1'b0, 1'b1, 12'h203, 1'b0, 1'b1, 12'h200, 1'b0, 12'h014, 1'b0, 32'd4);
    tbl[9]  = mk(1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 1'b1, 12'h204, 1'b1, 12'h204, 1'b0, 32'd4);
    tbl[10] = mk(1'b0, 1'b1, 1'b1, 12'hFFC, 1'b0, 1'b1, 12'hFFC, 1'b0, 12'h208, 1'b0, 32'd5);
    tbl[11] = mk(1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 1'b1, 12'h000, 1'b1, 12'h000, 1'b0, 32'd5);
    tbl[12] = mk(1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 1'b1, 12'h004, 1'b1, 12'h004, 1'b0, 32'd6);
    tbl[13] = mk(1'b0, 1'b1, 1'b1, 12'h100, 1'b1, 1'b0, 12'h000, 1'b0, 12'h008, 1'b0, 32'd7);
    tbl[14] = mk(1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 1'b1, 12'h004, 1'b0, 12'h008, 1'b1, 32'd7);
    tbl[15] = mk(1'b0, 1'b1, 1'b1, 12'h040, 1'b0, 1'b1, 12'h004, 1'b0, 12'h008, 1'b1, 32'd7);
    tbl[16] = mk(1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 1'b1, 12'h004, 1'b0, 12'h008, 1'b1, 32'd7);
    tbl[17] = mk(1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 1'b1, 12'h004, 1'b0, 12'h008, 1'b1, 32'd7);
    tbl[18] = mk(1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 1'b1, 12'h000, 1'b0, 12'h004, 1'b0, 32'd0);
    tbl[19] = mk(1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 1'b1, 12'h004, 1'b1, 12'h004, 1'b0, 32'd0);
    tbl[20] = mk(1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 12'h004, 1'b1, 12'h008, 1'b0, 32'd1);
    tbl[21] = mk(1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 12'h004, 1'b1, 12'h008, 1'b0, 32'd1);
    tbl[22] = mk(1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 12'h000, 1'b0, 12'h004, 1'b0, 32'd0);
    tbl[23] = mk(1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 12'h000, 1'b1, 12'h004, 1'b0, 32'd0);

    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 24; i++) begin
      apply(tbl[i], $sformatf("row%0d", i));
    end

    // Long run of sequential fetches after the post-reset stall.
    for (int k = 0; k < 8; k++) begin
      apply(mk(1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 1'b1, 12'(4 + 4 * k), 1'b1,
               12'(4 + 4 * k), 1'b0, 32'(k)), $sformatf("seq%0d", k));
    end

    // Redirect with go=1 to a misaligned target, then halt on an advance.
    apply(mk(1'b0, 1'b1, 1'b1, 12'h7FE, 1'b0, 1'b1, 12'h7FC, 1'b0, 12'h024, 1'b0, 32'd8), "redir_go");
    apply(mk(1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 1'b1, 12'h800, 1'b1, 12'h800, 1'b0, 32'd8), "after_redir");
    apply(mk(1'b0, 1'b1, 1'b0, 12'h000, 1'b1, 1'b1, 12'h804, 1'b0, 12'h804, 1'b0, 32'd9), "halt_req");
    apply(mk(1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 1'b1, 12'h800, 1'b0, 12'h804, 1'b1, 32'd9), "halted");
    apply(mk(1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 1'b1, 12'h800, 1'b0, 12'h804, 1'b1, 32'd9), "halted2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
